phy_rx_serial: RTL

Receive-side physical layer: recovers 32-bit words from the two serial lanes driven by the transmit PHY. Each lane is deserialised MSB-first into 8-bit characters. Each lane is aligned independently on the 0xBC idle/COM character. The four bytes are un-striped back into a word. The block sits between the lane pins and the receive data path, clocked at bit rate, and is the counterpart of the transmit PHY.

---
 rtl/phy_pkg.sv | 20 ++
 rtl/phy_rx_lane.sv | 102 ++++++++++
 rtl/phy_rx_serial.sv | 113 +++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions: idle/COM character, lane FSM encoding
// and byte-slot positions used by both transmit and receive sides.
package phy_pkg;

    localparam logic [7:0] COM_CHAR_DEF = 8'hBC;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_HUNT   = 2'd1,
        ST_COUNT  = 2'd2,
        ST_LOCKED = 2'd3
    } phy_lane_state_e;

    // Byte positions of each lane slot inside the 32-bit word
    localparam logic [1:0] SLOT_L0A = 2'd3;
    localparam logic [1:0] SLOT_L1A = 2'd2;
    localparam logic [1:0] SLOT_L0B = 2'd1;
    localparam logic [1:0] SLOT_L1B = 2'd0;

endpackage

// File: rtl/phy_rx_lane.sv
// One receive lane: MSB-first deserialiser, COM alignment FSM
// and A/B slot tracking with registered per-character strobes.
module phy_rx_lane
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM_CHAR   = COM_CHAR_DEF,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       din_i,
    input  logic       hunt_i,
    output logic       locked_o,
    output logic       com_o,
    output logic       com_b_o,
    output logic       a_o,
    output logic       b_o,
    output logic [7:0] char_o
);

    localparam logic [3:0] LC = 4'(LOCK_COUNT);

    phy_lane_state_e state_q;
    logic [7:0]      sr_q;
    logic [2:0]      bcnt_q;
    logic [3:0]      ccnt_q;
    logic            slot_q;
    logic            char_rdy;
    logic            is_com;

    assign char_rdy = (bcnt_q == 3'd7);
    assign is_com   = (sr_q == COM_CHAR);
    assign locked_o = (state_q == ST_LOCKED);

    // Shift, align on COM and classify each captured character
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RESET;
            sr_q    <= '0;
            bcnt_q  <= '0;
            ccnt_q  <= '0;
            slot_q  <= 1'b0;
            com_o   <= 1'b0;
            com_b_o <= 1'b0;
            a_o     <= 1'b0;
            b_o     <= 1'b0;
            char_o  <= '0;
        end else begin
            sr_q    <= {sr_q[6:0], din_i};
            bcnt_q  <= bcnt_q + 3'd1;
            com_o   <= 1'b0;
            com_b_o <= 1'b0;
            a_o     <= 1'b0;
            b_o     <= 1'b0;
            if (hunt_i) begin
                state_q <= ST_HUNT;
                ccnt_q  <= '0;
                slot_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_RESET: state_q <= ST_HUNT;
                    ST_HUNT: begin
                        if (is_com) begin
                            state_q <= ST_COUNT;
                            bcnt_q  <= '0;
                            ccnt_q  <= 4'd1;
                        end
                    end
                    ST_COUNT: begin
                        if (char_rdy) begin
                            if (!is_com) begin
                                state_q <= ST_HUNT;
                                ccnt_q  <= '0;
                            end else if (ccnt_q + 4'd1 >= LC) begin
                                state_q <= ST_LOCKED;
                                ccnt_q  <= LC;
                            end else begin
                                ccnt_q <= ccnt_q + 4'd1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (char_rdy) begin
                            if (is_com) begin
                                com_o   <= 1'b1;
                                com_b_o <= slot_q;
                                slot_q  <= 1'b0;
                            end else begin
                                char_o <= sr_q;
                                a_o    <= ~slot_q;
                                b_o    <= slot_q;
                                slot_q <= ~slot_q;
                            end
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: rtl/phy_rx_serial.sv
// Two-lane receive PHY: per-lane alignment, word un-striping and pairing check.
// Define PHY_RX_ERR_CNT_EN to add the saturating err_count_rx output.
module phy_rx_serial
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM_CHAR   = COM_CHAR_DEF,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_in_lane_0_rx,
    input  logic        data_in_lane_1_rx,
    output logic [31:0] data_out_rx,
    output logic        valid_out_rx,
    output logic        active_rx,
`ifdef PHY_RX_ERR_CNT_EN
    output logic        err_rx,
    output logic [7:0]  err_count_rx
`else
    output logic        err_rx
`endif
);

    logic [1:0]      lock_s, com_s, comb_s, a_s, b_s;
    logic [7:0]      ch0, ch1;
    logic [1:0]      got_a_q, got_a_d, got_b_q, got_b_d;
    logic [3:0][7:0] word_q, word_d;
    logic            err_d, done_d;

    phy_rx_lane #(.COM_CHAR(COM_CHAR), .LOCK_COUNT(LOCK_COUNT)) u_lane0 (
        .clk_i   (clk),
        .rst_ni  (reset),
        .din_i   (data_in_lane_0_rx),
        .hunt_i  (err_d),
        .locked_o(lock_s[0]),
        .com_o   (com_s[0]),
        .com_b_o (comb_s[0]),
        .a_o     (a_s[0]),
        .b_o     (b_s[0]),
        .char_o  (ch0)
    );

    phy_rx_lane #(.COM_CHAR(COM_CHAR), .LOCK_COUNT(LOCK_COUNT)) u_lane1 (
        .clk_i   (clk),
        .rst_ni  (reset),
        .din_i   (data_in_lane_1_rx),
        .hunt_i  (err_d),
        .locked_o(lock_s[1]),
        .com_o   (com_s[1]),
        .com_b_o (comb_s[1]),
        .a_o     (a_s[1]),
        .b_o     (b_s[1]),
        .char_o  (ch1)
    );

    // Collect slots into the word and detect lanes falling out of step
    always_comb begin
        word_d  = word_q;
        got_a_d = got_a_q | a_s;
        got_b_d = got_b_q | b_s;
        if (a_s[0]) word_d[SLOT_L0A] = ch0;
        if (a_s[1]) word_d[SLOT_L1A] = ch1;
        if (b_s[0]) word_d[SLOT_L0B] = ch0;
        if (b_s[1]) word_d[SLOT_L1B] = ch1;
        err_d = (|comb_s)
              | (com_s[0] & ~got_a_q[0] & got_a_d[1])
              | (com_s[1] & ~got_a_q[1] & got_a_d[0])
              | (b_s[0] & ~got_a_d[1])
              | (b_s[1] & ~got_a_d[0]);
        done_d = &got_b_d;
        if (err_d || done_d) begin
            got_a_d = '0;
            got_b_d = '0;
        end
    end

    // Register word progress and outputs; an error suppresses completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            got_a_q      <= '0;
            got_b_q      <= '0;
            word_q       <= '0;
            data_out_rx  <= '0;
            valid_out_rx <= 1'b0;
            active_rx    <= 1'b0;
            err_rx       <= 1'b0;
        end else begin
            got_a_q      <= got_a_d;
            got_b_q      <= got_b_d;
            word_q       <= word_d;
            valid_out_rx <= done_d & ~err_d;
            active_rx    <= &lock_s;
            err_rx       <= err_d;
            if (done_d && !err_d) data_out_rx <= word_d;
        end
    end

`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0] ecnt_q;

    // Saturating count of pairing errors, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ecnt_q <= '0;
        end else if (err_d && ecnt_q != 8'hFF) begin
            ecnt_q <= ecnt_q + 8'd1;
        end
    end

    assign err_count_rx = ecnt_q;
`endif

endmodule
